// File: rtl/pluse_guard.sv
// Shoot-through and dead-time guard for the four bridge switch drives.
// Registers the drives, enforces dead time between up/down groups and latches faults.
`timescale 1ns/1ps

module pluse_guard #(
    parameter int DEAD_W = 8
) (
    input  logic              clk_sys,
    input  logic              rst_n,
    input  logic              guard_en,
    input  logic [DEAD_W-1:0] dead_para,
    input  logic              fault_clr,
    input  logic              Q1Q8_in,
    input  logic              Q2Q7_in,
    input  logic              Q3Q6_in,
    input  logic              Q4Q5_in,
    output logic              Q1Q8,
    output logic              Q2Q7,
    output logic              Q3Q6,
    output logic              Q4Q5,
    output logic              fault,
    output logic [1:0]        fault_code,
    output logic [7:0]        fault_cnt
);

    typedef enum logic [2:0] {
        ST_OFF,
        ST_UP,
        ST_DOWN,
        ST_DEAD_UP,
        ST_DEAD_DN,
        ST_FAULT
    } state_e;

    localparam logic [1:0] CODE_NONE    = 2'b00;
    localparam logic [1:0] CODE_OVERLAP = 2'b01;
    localparam logic [1:0] CODE_DEAD    = 2'b10;

    // Drive vector bit order: {Q4Q5, Q3Q6, Q2Q7, Q1Q8}.
    localparam logic [3:0] UP_MASK = 4'b0101;
    localparam logic [3:0] DN_MASK = 4'b1010;

    localparam logic [DEAD_W-1:0] CNT_ONE = DEAD_W'(1);

    logic [3:0]        in_vec;
    logic              up_req;
    logic              dn_req;
    logic              dead_zero;
    logic              bypass;

    state_e            state_q,     state_d;
    logic [DEAD_W-1:0] cnt_q,       cnt_d;
    logic [3:0]        drv_q,       drv_d;
    logic              fault_q,     fault_d;
    logic [1:0]        code_q,      code_d;
    logic [7:0]        fcnt_q,      fcnt_d;

    logic              trip;
    logic [1:0]        trip_code;

    assign in_vec    = {Q4Q5_in, Q3Q6_in, Q2Q7_in, Q1Q8_in};
    assign up_req    = Q1Q8_in | Q3Q6_in;
    assign dn_req    = Q2Q7_in | Q4Q5_in;
    assign dead_zero = (dead_para == '0);

    // Pass-through only applies outside FAULT; a latched fault must be cleared first.
    assign bypass    = !guard_en && (state_q != ST_FAULT);

    // Transition logic for the guard FSM and the dead-time counter.
    always_comb begin
        // NOTE: every variable gets a default before the case so no latch is inferred.
        state_d   = state_q;
        cnt_d     = cnt_q;
        trip      = 1'b0;
        trip_code = CODE_NONE;

        unique case (state_q)
            ST_OFF: begin
                if (up_req && dn_req) begin
                    trip      = 1'b1;
                    trip_code = CODE_OVERLAP;
                end else if (up_req) begin
                    state_d = ST_UP;
                end else if (dn_req) begin
                    state_d = ST_DOWN;
                end
            end

            ST_UP: begin
                if (dn_req) begin
                    if (dead_zero && !up_req) begin
                        state_d = ST_DOWN;
                    end else begin
                        trip      = 1'b1;
                        trip_code = up_req ? CODE_OVERLAP : CODE_DEAD;
                    end
                end else if (!up_req) begin
                    if (dead_zero) begin
                        state_d = ST_OFF;
                    end else begin
                        state_d = ST_DEAD_UP;
                        cnt_d   = dead_para - CNT_ONE;
                    end
                end
            end

            ST_DOWN: begin
                if (up_req) begin
                    if (dead_zero && !dn_req) begin
                        state_d = ST_UP;
                    end else begin
                        trip      = 1'b1;
                        trip_code = dn_req ? CODE_OVERLAP : CODE_DEAD;
                    end
                end else if (!dn_req) begin
                    if (dead_zero) begin
                        state_d = ST_OFF;
                    end else begin
                        state_d = ST_DEAD_DN;
                        cnt_d   = dead_para - CNT_ONE;
                    end
                end
            end

            ST_DEAD_UP: begin
                if (up_req && dn_req) begin
                    trip      = 1'b1;
                    trip_code = CODE_OVERLAP;
                end else if (up_req) begin
                    state_d = ST_UP;
                end else if (dn_req) begin
                    if (cnt_q == '0) begin
                        state_d = ST_DOWN;
                    end else begin
                        trip      = 1'b1;
                        trip_code = CODE_DEAD;
                    end
                end else if (cnt_q == '0) begin
                    state_d = ST_OFF;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            ST_DEAD_DN: begin
                if (up_req && dn_req) begin
                    trip      = 1'b1;
                    trip_code = CODE_OVERLAP;
                end else if (dn_req) begin
                    state_d = ST_DOWN;
                end else if (up_req) begin
                    if (cnt_q == '0) begin
                        state_d = ST_UP;
                    end else begin
                        trip      = 1'b1;
                        trip_code = CODE_DEAD;
                    end
                end else if (cnt_q == '0) begin
                    state_d = ST_OFF;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            ST_FAULT: begin
                if (fault_clr && !up_req && !dn_req) begin
                    state_d = ST_OFF;
                end
            end

            default: state_d = ST_OFF;
        endcase

        if (trip) begin
            state_d = ST_FAULT;
        end

        if (bypass) begin
            state_d   = ST_OFF;
            cnt_d     = '0;
            trip      = 1'b0;
            trip_code = CODE_NONE;
        end
    end

    // Drive outputs follow the state being entered, so they share its one-cycle latency.
    always_comb begin
        drv_d = '0;
        unique case (state_d)
            ST_UP:   drv_d = in_vec & UP_MASK;
            ST_DOWN: drv_d = in_vec & DN_MASK;
            default: drv_d = '0;
        endcase
        if (bypass) begin
            drv_d = in_vec;
        end
    end

    always_comb begin
        fault_d = fault_q;
        code_d  = code_q;
        fcnt_d  = fcnt_q;
        if (trip) begin
            fault_d = 1'b1;
            code_d  = trip_code;
            if (fcnt_q != 8'hFF) begin
                fcnt_d = fcnt_q + 8'd1;
            end
        end else if ((state_q == ST_FAULT) && (state_d == ST_OFF)) begin
            fault_d = 1'b0;
            code_d  = CODE_NONE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
            drv_q   <= '0;
            fault_q <= 1'b0;
            code_q  <= CODE_NONE;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            drv_q   <= drv_d;
            fault_q <= fault_d;
            code_q  <= code_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign Q1Q8       = drv_q[0];
    assign Q2Q7       = drv_q[1];
    assign Q3Q6       = drv_q[2];
    assign Q4Q5       = drv_q[3];
    assign fault      = fault_q;
    assign fault_code = code_q;
    assign fault_cnt  = fcnt_q;

endmodule
